// File: rtl/wb_pipe_reg_if.sv
// wb_pipe_reg_if: MEM->WB bundle; master drives stall_cur/stall_nxt/flush/mem_*, slave drives wb_* (+bubble_cnt under WB_PERF_CNT_EN)
interface wb_pipe_reg_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
`ifdef WB_PERF_CNT_EN
    , parameter int CNT_W = 16
`endif
);
    logic stall_cur, stall_nxt, flush;
    logic [NUM_CH*ADDR_W-1:0] mem_wd, wb_wd;
    logic [NUM_CH-1:0] mem_wreg, wb_wreg;
    logic [NUM_CH*DATA_W-1:0] mem_wdata, wb_wdata;
    logic [DATA_W-1:0] mem_hi, mem_lo, wb_hi, wb_lo, mem_cp0_wdata, wb_cp0_wdata;
    logic mem_whilo, wb_whilo, mem_cp0_we, wb_cp0_we, wb_valid;
    logic [4:0] mem_cp0_waddr, wb_cp0_waddr;
`ifdef WB_PERF_CNT_EN
    logic [CNT_W-1:0] bubble_cnt;
`endif
    modport master (
`ifdef WB_PERF_CNT_EN
        input bubble_cnt,
`endif
        output stall_cur, stall_nxt, flush, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
        output mem_cp0_we, mem_cp0_waddr, mem_cp0_wdata,
        input wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo, wb_cp0_we, wb_cp0_waddr, wb_cp0_wdata, wb_valid
    );
    modport slave (
`ifdef WB_PERF_CNT_EN
        output bubble_cnt,
`endif
        input stall_cur, stall_nxt, flush, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
        input mem_cp0_we, mem_cp0_waddr, mem_cp0_wdata,
        output wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo, wb_cp0_we, wb_cp0_waddr, wb_cp0_wdata, wb_valid
    );
endinterface

// File: rtl/wb_pipe_reg.sv
// wb_pipe_reg: MEM->WB pipeline register (flush > bubble > capture > hold); ports clk, rst, bus (wb_pipe_reg_if.slave); WB_PERF_CNT_EN adds bubble_cnt
module wb_pipe_reg #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
`ifdef WB_PERF_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input logic clk,
    input logic rst,
    wb_pipe_reg_if.slave bus
);
    logic bubble, capture;
    logic [NUM_CH-1:0] wreg_m, wreg_d, wreg_q;
    logic [NUM_CH*ADDR_W-1:0] wd_d, wd_q;
    logic [NUM_CH*DATA_W-1:0] wdata_d, wdata_q;
    logic [DATA_W-1:0] hi_d, hi_q, lo_d, lo_q, cp0_wdata_d, cp0_wdata_q;
    logic whilo_d, whilo_q, cp0_we_d, cp0_we_q, valid_d, valid_q;
    logic [4:0] cp0_waddr_d, cp0_waddr_q;
    assign bubble = bus.flush || (bus.stall_cur && !bus.stall_nxt);
    assign capture = !bus.stall_cur;
    always_comb begin
        wreg_m = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            wreg_m[j] = bus.mem_wreg[j] && (bus.mem_wd[j*ADDR_W +: ADDR_W] != '0);
            for (int k = j + 1; k < NUM_CH; k++)
                wreg_m[j] = (bus.mem_wreg[k] && bus.mem_wd[k*ADDR_W +: ADDR_W] == bus.mem_wd[j*ADDR_W +: ADDR_W]) ? 1'b0 : wreg_m[j];
        end
    end
    always_comb begin
        wd_d        = bubble ? '0   : capture ? bus.mem_wd        : wd_q;
        wreg_d      = bubble ? '0   : capture ? wreg_m            : wreg_q;
        wdata_d     = bubble ? '0   : capture ? bus.mem_wdata     : wdata_q;
        hi_d        = bubble ? '0   : capture ? bus.mem_hi        : hi_q;
        lo_d        = bubble ? '0   : capture ? bus.mem_lo        : lo_q;
        whilo_d     = bubble ? 1'b0 : capture ? bus.mem_whilo     : whilo_q;
        cp0_we_d    = bubble ? 1'b0 : capture ? bus.mem_cp0_we    : cp0_we_q;
        cp0_waddr_d = bubble ? '0   : capture ? bus.mem_cp0_waddr : cp0_waddr_q;
        cp0_wdata_d = bubble ? '0   : capture ? bus.mem_cp0_wdata : cp0_wdata_q;
        valid_d     = bubble ? 1'b0 : capture ? 1'b1              : valid_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
            wreg_q <= '0;
            wdata_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
            whilo_q <= 1'b0;
            cp0_we_q <= 1'b0;
            cp0_waddr_q <= '0;
            cp0_wdata_q <= '0;
            valid_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            wreg_q <= wreg_d;
            wdata_q <= wdata_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            whilo_q <= whilo_d;
            cp0_we_q <= cp0_we_d;
            cp0_waddr_q <= cp0_waddr_d;
            cp0_wdata_q <= cp0_wdata_d;
            valid_q <= valid_d;
        end
    end
    assign bus.wb_wd = wd_q;
    assign bus.wb_wreg = wreg_q;
    assign bus.wb_wdata = wdata_q;
    assign bus.wb_hi = hi_q;
    assign bus.wb_lo = lo_q;
    assign bus.wb_whilo = whilo_q;
    assign bus.wb_cp0_we = cp0_we_q;
    assign bus.wb_cp0_waddr = cp0_waddr_q;
    assign bus.wb_cp0_wdata = cp0_wdata_q;
    assign bus.wb_valid = valid_q;
`ifdef WB_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_d, cnt_q;
    always_comb cnt_d = (bubble && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
    assign bus.bubble_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_wb_pipe_reg.sv
// tb_wb_pipe_reg: directed self-checking bench for wb_pipe_reg (counter checks only with WB_PERF_CNT_EN)
module tb_wb_pipe_reg;
    logic clk = 1'b0;
    logic rst;
    int total = 0;
    int bad = 0;
    int exp_cnt = 0;
    always #5 clk = ~clk;
`ifdef WB_PERF_CNT_EN
    wb_pipe_reg_if #(.NUM_CH(2), .DATA_W(32), .ADDR_W(5), .CNT_W(4)) bus();
    wb_pipe_reg #(.NUM_CH(2), .DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
    wb_pipe_reg_if #(.NUM_CH(2), .DATA_W(32), .ADDR_W(5)) bus();
    wb_pipe_reg #(.NUM_CH(2), .DATA_W(32), .ADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif
    logic [179:0] outs;
    assign outs = {bus.wb_wd, bus.wb_wreg, bus.wb_wdata, bus.wb_hi, bus.wb_lo, bus.wb_whilo,
                   bus.wb_cp0_we, bus.wb_cp0_waddr, bus.wb_cp0_wdata, bus.wb_valid};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bump();
        exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
    endtask

    task automatic set_idle();
        bus.stall_cur = 1'b0;
        bus.stall_nxt = 1'b0;
        bus.flush = 1'b0;
        bus.mem_wd = '0;
        bus.mem_wreg = '0;
        bus.mem_wdata = '0;
        bus.mem_hi = '0;
        bus.mem_lo = '0;
        bus.mem_whilo = 1'b0;
        bus.mem_cp0_we = 1'b0;
        bus.mem_cp0_waddr = '0;
        bus.mem_cp0_wdata = '0;
    endtask

    task automatic set_garbage();
        bus.mem_wd = {5'd17, 5'd9};
        bus.mem_wreg = 2'b11;
        bus.mem_wdata = {32'hCAFEF00D, 32'h01234567};
        bus.mem_hi = 32'hFFFF0000;
        bus.mem_lo = 32'h0000FFFF;
        bus.mem_whilo = 1'b1;
        bus.mem_cp0_we = 1'b1;
        bus.mem_cp0_waddr = 5'd31;
        bus.mem_cp0_wdata = 32'h87654321;
    endtask

    task automatic test_reset();
        set_idle();
        set_garbage();
        rst = 1'b1;
        step();
        step();
        total++;
        if (outs !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", outs); end
`ifdef WB_PERF_CNT_EN
        total++;
        if (bus.bubble_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bus.bubble_cnt); end
`endif
        exp_cnt = 0;
        rst = 1'b0;
    endtask

    task automatic test_capture();
        set_idle();
        bus.mem_wd = {5'd0, 5'd3};
        bus.mem_wreg = 2'b01;
        bus.mem_wdata = {32'h0, 32'hDEADBEEF};
        #1;
        total++;
        if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL capture_latency got=%b exp=0", bus.wb_valid); end
        step();
        total++;
        if (bus.wb_wd[4:0] !== 5'd3) begin bad++; $display("FAIL capture_wd got=%0d exp=3", bus.wb_wd[4:0]); end
        total++;
        if (bus.wb_wreg !== 2'b01) begin bad++; $display("FAIL capture_wreg got=%b exp=01", bus.wb_wreg); end
        total++;
        if (bus.wb_wdata[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL capture_wdata got=%h exp=deadbeef", bus.wb_wdata[31:0]); end
        total++;
        if (bus.wb_valid !== 1'b1) begin bad++; $display("FAIL capture_valid got=%b exp=1", bus.wb_valid); end
    endtask

    task automatic test_mask();
        logic [9:0] tw [6];
        logic [1:0] tr [6];
        logic [1:0] te [6];
        tw[0] = {5'd7, 5'd7}; tr[0] = 2'b11; te[0] = 2'b10;
        tw[1] = {5'd9, 5'd0}; tr[1] = 2'b01; te[1] = 2'b00;
        tw[2] = {5'd9, 5'd8}; tr[2] = 2'b11; te[2] = 2'b11;
        tw[3] = {5'd7, 5'd7}; tr[3] = 2'b01; te[3] = 2'b01;
        tw[4] = {5'd0, 5'd0}; tr[4] = 2'b11; te[4] = 2'b00;
        tw[5] = {5'd0, 5'd5}; tr[5] = 2'b10; te[5] = 2'b00;
        set_idle();
        for (int i = 0; i < 6; i++) begin
            bus.mem_wd = tw[i];
            bus.mem_wreg = tr[i];
            bus.mem_wdata = {32'h22 + 32'(i), 32'h11 + 32'(i)};
            step();
            total++;
            if (bus.wb_wreg !== te[i]) begin bad++; $display("FAIL mask_wreg[%0d] got=%b exp=%b", i, bus.wb_wreg, te[i]); end
            total++;
            if (bus.wb_wd !== tw[i]) begin bad++; $display("FAIL mask_wd[%0d] got=%h exp=%h", i, bus.wb_wd, tw[i]); end
            total++;
            if (bus.wb_wdata !== {32'h22 + 32'(i), 32'h11 + 32'(i)}) begin
                bad++; $display("FAIL mask_wdata[%0d] got=%h exp=%h", i, bus.wb_wdata, {32'h22 + 32'(i), 32'h11 + 32'(i)});
            end
        end
    endtask

    task automatic test_hold_bubble();
        logic [179:0] exp;
        set_idle();
        bus.mem_wd = {5'd0, 5'd3};
        bus.mem_wreg = 2'b01;
        bus.mem_wdata = {32'h0, 32'h99};
        bus.mem_whilo = 1'b1;
        bus.mem_hi = 32'hA;
        bus.mem_lo = 32'hB;
        bus.mem_cp0_we = 1'b1;
        bus.mem_cp0_waddr = 5'd12;
        bus.mem_cp0_wdata = 32'h55;
        exp = {10'd3, 2'b01, 64'h99, 32'hA, 32'hB, 1'b1, 1'b1, 5'd12, 32'h55, 1'b1};
        step();
        total++;
        if (outs !== exp) begin bad++; $display("FAIL hilo_capture got=%h exp=%h", outs, exp); end
        bus.stall_cur = 1'b1;
        bus.stall_nxt = 1'b1;
        set_garbage();
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (outs !== exp) begin bad++; $display("FAIL hold[%0d] got=%h exp=%h", i, outs, exp); end
        end
        bus.stall_nxt = 1'b0;
        step();
        bump();
        total++;
        if (outs !== '0) begin bad++; $display("FAIL bubble_outputs got=%h exp=0", outs); end
`ifdef WB_PERF_CNT_EN
        total++;
        if (bus.bubble_cnt !== 4'(exp_cnt)) begin bad++; $display("FAIL bubble_cnt got=%0d exp=%0d", bus.bubble_cnt, exp_cnt); end
`endif
    endtask

    task automatic test_flush();
        logic [1:0] st [3];
        st[0] = 2'b11; st[1] = 2'b00; st[2] = 2'b10;
        for (int i = 0; i < 3; i++) begin
            set_idle();
            bus.mem_cp0_we = 1'b1;
            bus.mem_cp0_waddr = 5'd3;
            bus.mem_cp0_wdata = 32'h77;
            bus.mem_wd = {5'd0, 5'd2};
            bus.mem_wreg = 2'b01;
            step();
            total++;
            if (bus.wb_cp0_we !== 1'b1 || bus.wb_valid !== 1'b1) begin
                bad++; $display("FAIL flush_pre[%0d] got=%b%b exp=11", i, bus.wb_cp0_we, bus.wb_valid);
            end
            bus.flush = 1'b1;
            {bus.stall_cur, bus.stall_nxt} = st[i];
            step();
            bump();
            total++;
            if (outs !== '0) begin bad++; $display("FAIL flush_outputs[%0d] got=%h exp=0", i, outs); end
`ifdef WB_PERF_CNT_EN
            total++;
            if (bus.bubble_cnt !== 4'(exp_cnt)) begin bad++; $display("FAIL flush_cnt[%0d] got=%0d exp=%0d", i, bus.bubble_cnt, exp_cnt); end
`endif
        end
    endtask

    task automatic test_illegal();
        set_idle();
        bus.stall_nxt = 1'b1;
        bus.mem_whilo = 1'b1;
        bus.mem_hi = 32'h1234;
        $display("note: illegal stall_cur=0 stall_nxt=1 driven, capture expected");
        step();
        total++;
        if (bus.wb_valid !== 1'b1 || bus.wb_hi !== 32'h1234 || bus.wb_whilo !== 1'b1) begin
            bad++; $display("FAIL illegal_capture got=%b/%h exp=1/00001234", bus.wb_valid, bus.wb_hi);
        end
    endtask

    task automatic test_rst_override();
        set_idle();
        set_garbage();
        step();
        bus.stall_cur = 1'b1;
        bus.stall_nxt = 1'b1;
        rst = 1'b1;
        step();
        exp_cnt = 0;
        total++;
        if (outs !== '0) begin bad++; $display("FAIL rst_mid_hold got=%h exp=0", outs); end
        rst = 1'b0;
        step();
        total++;
        if (outs !== '0) begin bad++; $display("FAIL hold_after_rst got=%h exp=0", outs); end
        bus.flush = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.flush = 1'b0;
`ifdef WB_PERF_CNT_EN
        total++;
        if (bus.bubble_cnt !== 4'd0) begin bad++; $display("FAIL rst_mid_flush_cnt got=%0d exp=0", bus.bubble_cnt); end
`endif
        bus.stall_cur = 1'b0;
        bus.stall_nxt = 1'b0;
        bus.mem_lo = 32'h5;
        step();
        total++;
        if (bus.wb_valid !== 1'b1 || bus.wb_lo !== 32'h5) begin
            bad++; $display("FAIL capture_after_rst got=%b/%h exp=1/00000005", bus.wb_valid, bus.wb_lo);
        end
    endtask

    task automatic test_saturate();
        set_idle();
        bus.stall_cur = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            bump();
        end
        total++;
        if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL sat_valid got=%b exp=0", bus.wb_valid); end
`ifdef WB_PERF_CNT_EN
        total++;
        if (bus.bubble_cnt !== 4'd15) begin bad++; $display("FAIL sat_cnt got=%0d exp=15", bus.bubble_cnt); end
`endif
        rst = 1'b1;
        step();
        exp_cnt = 0;
        rst = 1'b0;
`ifdef WB_PERF_CNT_EN
        total++;
        if (bus.bubble_cnt !== 4'd0) begin bad++; $display("FAIL sat_rst_cnt got=%0d exp=0", bus.bubble_cnt); end
`endif
        total++;
        if (outs !== '0) begin bad++; $display("FAIL sat_rst_outputs got=%h exp=0", outs); end
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        test_reset();
        test_capture();
        test_mask();
        test_hold_bubble();
        test_flush();
        test_illegal();
        test_rst_override();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_pipe_reg.md
WB_PIPE_REG -- requirements
Module: wb_pipe_reg

Interface
REQ-001 Parameter NUM_CH, default 2: number of GPR write channels carried MEM->WB (1..4).
REQ-002 Parameter DATA_W, default 32: register and HI/LO data width.
REQ-003 Parameter ADDR_W, default 5: GPR address width.
REQ-004 Parameter CNT_W, default 16: bubble-counter width.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 stall_cur  in  1  MEM stage stalled (stall bit 4 equivalent).
REQ-008 stall_nxt  in  1  WB stage stalled (stall bit 5 equivalent).
REQ-009 flush  in  1  exception flush; squashes the captured instruction.
REQ-010 mem_wd  in  NUM_CH*ADDR_W  per-channel GPR destination; channel k in bits [k*ADDR_W +: ADDR_W].
REQ-011 mem_wreg  in  NUM_CH  per-channel GPR write enable.
REQ-012 mem_wdata  in  NUM_CH*DATA_W  per-channel GPR write data.
REQ-013 mem_hi, mem_lo  in  DATA_W each  HI/LO write data; mem_whilo  in  1  HI/LO write enable.
REQ-014 mem_cp0_we  in  1; mem_cp0_waddr  in  5; mem_cp0_wdata  in  DATA_W: CP0 write channel.
REQ-015 wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo, wb_cp0_we, wb_cp0_waddr, wb_cp0_wdata  out  widths match corresponding mem_* inputs: registered WB-side copies.
REQ-016 wb_valid  out  1  WB slot holds a real (non-bubble) instruction.
REQ-017 bubble_cnt  out  CNT_W  bubbles inserted since reset (present only per REQ-034).

Function
REQ-018 All outputs SHALL be registered; capture latency exactly one clk from mem_* to wb_*.
REQ-019 Priority each edge: rst > flush > bubble > capture > hold.
REQ-020 flush=1 SHALL load bubble regardless of stall_cur/stall_nxt.
REQ-021 Bubble (stall_cur=1, stall_nxt=0, flush=0): all enables and wb_valid 0, all data/address fields 0.
REQ-022 Capture (stall_cur=0, flush=0): load all mem_* fields, set wb_valid=1.
REQ-023 Hold (stall_cur=1, stall_nxt=1, flush=0): all outputs retain value.
REQ-024 Capture SHALL clear wb_wreg[k] when mem_wd channel k equals 0; its wb_wdata field still loaded.
REQ-025 Capture SHALL clear wb_wreg[j] when a higher-index channel k>j has mem_wreg[k]=1 and same nonzero address (highest channel wins).
REQ-026 REQ-024/025 masking SHALL not alter wb_wd or wb_wdata fields.
REQ-027 stall_cur=0 with stall_nxt=1 is illegal; block SHALL capture (REQ-022); bench flags it.
REQ-028 Bubble counter increments by 1 on each edge applying REQ-020 or REQ-021, saturates at all-ones, never wraps.
REQ-029 Flush on an edge where hold would apply SHALL still count as one bubble.

Reset
REQ-030 rst=1 at an edge: all wb_* outputs 0, wb_valid 0, bubble_cnt 0.
REQ-031 rst asserted mid-hold or mid-flush SHALL override; first edge after rst deasserts follows REQ-019 normally.
REQ-032 No output SHALL be X after the first reset edge.

Configuration
REQ-033 Macro WB_PERF_CNT_EN selects the bubble counter.
REQ-034 Defined: counter, bubble_cnt port and REQ-028/029 present. Undefined: port absent, no counter flops; all other behaviour identical.

Verification
REQ-035 rst 1 cycle, then capture ch0 wd=3 wreg=1 wdata=0xDEADBEEF -> next edge wb_wd[0]=3, wb_wreg[0]=1, wb_wdata[0]=0xDEADBEEF, wb_valid=1.
REQ-036 Capture both channels wd=7 wreg=1, data 0x11/0x22 -> wb_wreg=2'b10, both data fields loaded; ch0 wd=0 wreg=1 -> wb_wreg[0]=0.
REQ-037 Capture whilo=1 hi=0xA lo=0xB; then stall_cur=1 stall_nxt=1 for 3 cycles -> outputs unchanged; then stall_nxt=0 -> all 0, wb_valid=0, bubble_cnt +1.
REQ-038 flush=1 with stall_cur=stall_nxt=1 and cp0_we=1 -> next edge wb_cp0_we=0, wb_valid=0, bubble_cnt +1.
REQ-039 CNT_W=4, 20 consecutive bubbles -> bubble_cnt=15; rst -> 0; build without WB_PERF_CNT_EN passes REQ-035..038 minus counter checks.
